// File: rtl/pri_arbiter.sv
// Four-requester arbiter with selectable fixed-priority / round-robin arbitration,
// a per-grant hold timeout, and a mandatory idle cycle between consecutive grants.
module pri_arbiter #(
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   input  logic       mode,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       tmo
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_reg;
   logic [7:0] cnt_reg;
   logic [1:0] last_reg;

   logic [1:0] fixed_id;
   logic [1:0] rr_id;
   logic [1:0] win_id;
   logic [1:0] cand [4];
   logic       release_now;

   always_comb begin
      fixed_id = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (req[i]) fixed_id = 2'(i);
      end
   end

   // cand[k] is the k-th index visited when searching upward from last_reg+1
   for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = last_reg + 2'(gi + 1);
   end

   always_comb begin
      rr_id = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req[cand[i]]) rr_id = cand[i];
      end
   end

   assign win_id      = mode ? rr_id : fixed_id;
   assign release_now = done || !req[gnt_id] || (cnt_reg == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         gnt       <= 4'b0000;
         gnt_id    <= 2'd0;
         busy      <= 1'b0;
         tmo       <= 1'b0;
         cnt_reg   <= 8'd0;
         last_reg  <= 2'd3;
      end else begin
         case (state_reg)
            IDLE: begin
               tmo <= 1'b0;
               if (req != 4'b0000) begin
                  state_reg <= GRANT;
                  gnt       <= 4'(1) << win_id;
                  gnt_id    <= win_id;
                  busy      <= 1'b1;
                  cnt_reg   <= 8'd0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state_reg <= IDLE;
                  gnt       <= 4'b0000;
                  gnt_id    <= 2'd0;
                  busy      <= 1'b0;
                  last_reg  <= gnt_id;
                  // only a pure timeout flags tmo; done or a dropped request win
                  tmo       <= !done && req[gnt_id];
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
                  tmo     <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pri_arbiter.sv
// Testbench for pri_arbiter: behavioural model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_pri_arbiter;

   localparam int TO = 8;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic       mode;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       tmo;

   int n_checks = 0;
   int n_fail   = 0;

   pri_arbiter #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .done  (done),
      .mode  (mode),
      .gnt   (gnt),
      .gnt_id(gnt_id),
      .busy  (busy),
      .tmo   (tmo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: who owns the bus, how many cycles it has been visible,
   // and who was released last.
   int m_busy  = 0;
   int m_owner = 0;
   int m_held  = 0;
   int m_last  = 3;
   int m_tmo   = 0;

   always @(posedge clk) begin
      int w;
      int found;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_held = 0; m_last = 3; m_tmo = 0;
      end else if (m_busy == 0) begin
         m_tmo = 0;
         if (req != 4'b0000) begin
            w = 0;
            if (mode == 1'b0) begin
               for (int i = 0; i < 4; i++) if (req[i]) w = i;
            end else begin
               found = 0;
               for (int k = 1; k <= 4; k++) begin
                  if (found == 0 && req[(m_last + k) % 4]) begin
                     w = (m_last + k) % 4;
                     found = 1;
                  end
               end
            end
            m_busy = 1; m_owner = w; m_held = 1;
         end
      end else begin
         if (done || !req[m_owner] || m_held == TO) begin
            m_tmo  = (!done && req[m_owner]) ? 1 : 0;
            m_last = m_owner;
            m_busy = 0; m_owner = 0; m_held = 0;
         end else begin
            m_held = m_held + 1;
            m_tmo  = 0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic lit(input string name, input int act, input int exp);
      chk(name, act, exp);
      $display("lit %s actual=%0d expected=%0d", name, act, exp);
   endtask

   // Every-cycle comparison against the model plus structural invariants.
   always @(negedge clk) begin
      int exp_gnt;
      exp_gnt = (m_busy != 0) ? (1 << m_owner) : 0;
      chk("gnt",    int'(gnt),    exp_gnt);
      chk("gnt_id", int'(gnt_id), m_owner);
      chk("busy",   int'(busy),   m_busy);
      chk("tmo",    int'(tmo),    m_tmo);
      if (busy) chk("onehot", int'(gnt), 1 << gnt_id);
      else      chk("idle_zero", int'({gnt, gnt_id}), 0);
   end

   typedef struct { logic [3:0] r; logic m; logic d; } vec_t;
   vec_t vecs [16];

   initial begin
      rst = 1'b1; req = 4'b0000; done = 1'b0; mode = 1'b0;
      repeat (2) @(negedge clk);
      lit("rst_gnt",  int'(gnt),  0);
      lit("rst_busy", int'(busy), 0);
      lit("rst_tmo",  int'(tmo),  0);

      // Fixed priority with timeout and regrant
      rst = 1'b0; mode = 1'b0; req = 4'b0101;
      @(negedge clk);
      lit("fp_gnt", int'(gnt), 4);
      lit("fp_id",  int'(gnt_id), 2);
      repeat (8) @(negedge clk);
      lit("to_tmo", int'(tmo), 1);
      lit("to_gnt", int'(gnt), 0);
      @(negedge clk);
      lit("regrant_gnt", int'(gnt), 4);
      lit("regrant_tmo", int'(tmo), 0);
      // Owner drops its request
      req = 4'b0001;
      @(negedge clk);
      lit("drop_busy", int'(busy), 0);
      lit("drop_tmo",  int'(tmo), 0);
      @(negedge clk);
      lit("drop_next_id", int'(gnt_id), 0);
      req = 4'b0000;
      @(negedge clk);

      // Round robin from reset
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mode = 1'b1; req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         lit("rr_id", int'(gnt_id), n % 4);
         mode = ~mode;  // ignored while granted
         done = 1'b1;
         @(negedge clk);
         mode = 1'b1;
         done = 1'b0;
         lit("rr_gap", int'(busy), 0);
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);

      // No preemption by a higher request
      mode = 1'b0; req = 4'b0010;
      @(negedge clk);
      lit("np_gnt", int'(gnt), 2);
      req = 4'b1010;
      repeat (3) @(negedge clk);
      lit("np_hold", int'(gnt), 2);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      lit("np_rel", int'(gnt), 0);
      @(negedge clk);
      lit("np_next", int'(gnt), 8);

      // Reset during grant
      req = 4'b1000;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      lit("rg_gnt",  int'(gnt), 0);
      lit("rg_busy", int'(busy), 0);
      rst = 1'b0; mode = 1'b1; req = 4'b1001;
      @(negedge clk);
      lit("rg_rr_id", int'(gnt_id), 0);
      req = 4'b0000;
      @(negedge clk);

      // done in IDLE is ignored
      done = 1'b1;
      repeat (2) @(negedge clk);
      lit("idle_done", int'(busy), 0);
      done = 1'b0;

      // Mixed directed vectors checked by the model
      vecs[0]  = '{4'b0110, 1'b1, 1'b0}; vecs[1]  = '{4'b0110, 1'b1, 1'b0};
      vecs[2]  = '{4'b0110, 1'b1, 1'b1}; vecs[3]  = '{4'b0110, 1'b1, 1'b0};
      vecs[4]  = '{4'b0110, 1'b1, 1'b0}; vecs[5]  = '{4'b0100, 1'b0, 1'b0};
      vecs[6]  = '{4'b1001, 1'b0, 1'b0}; vecs[7]  = '{4'b1001, 1'b0, 1'b0};
      vecs[8]  = '{4'b0001, 1'b1, 1'b0}; vecs[9]  = '{4'b0011, 1'b1, 1'b0};
      vecs[10] = '{4'b0011, 1'b1, 1'b1}; vecs[11] = '{4'b1100, 1'b1, 1'b0};
      vecs[12] = '{4'b1100, 1'b0, 1'b0}; vecs[13] = '{4'b1100, 1'b1, 1'b0};
      vecs[14] = '{4'b0000, 1'b1, 1'b1}; vecs[15] = '{4'b1010, 1'b1, 1'b0};
      for (int v = 0; v < 16; v++) begin
         req = vecs[v].r; mode = vecs[v].m; done = vecs[v].d;
         @(negedge clk);
      end
      req = 4'b1010; mode = 1'b1; done = 1'b0;
      repeat (20) @(negedge clk);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pri_arbiter.md
PRI_ARBITER -- requirements
Module: pri_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8, maximum cycles one grant is held (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request lines, req[i] from requester i.
REQ-005 done  input  1  current owner finished; releases grant.
REQ-006 mode  input  1  0 = fixed priority (req[3] highest, req[0] lowest); 1 = round robin.
REQ-007 gnt  output  4  one-hot grant, registered.
REQ-008 gnt_id  output  2  binary index of granted requester, registered.
REQ-009 busy  output  1  high while any grant is asserted, registered.
REQ-010 tmo  output  1  one-cycle pulse when a grant is force-released by timeout, registered.

Function
REQ-011 FSM states SHALL be IDLE and GRANT; reset state is IDLE.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE with gnt=0, gnt_id=0, busy=0.
REQ-013 In IDLE with req != 0 at edge N, the block SHALL select a winner, enter GRANT, and drive gnt, gnt_id and busy from edge N (one-cycle latency from request to grant).
REQ-014 Fixed priority (mode=0): winner SHALL be the highest-indexed asserted req bit (req=4'b1xxx -> id 3, 4'b01xx -> id 2, 4'b001x -> id 1, 4'b0001 -> id 0).
REQ-015 Round robin (mode=1): winner SHALL be the first asserted req bit searching from index last+1 upward, wrapping 3->0, where last is the index of the most recently released grant.
REQ-016 mode SHALL be sampled only at arbitration (IDLE) edges; changing it during GRANT has no effect on the current owner.
REQ-017 gnt SHALL be exactly one-hot whenever busy=1 and gnt_id SHALL equal the index of the set bit.
REQ-018 In GRANT, a 8-bit hold counter SHALL clear to 0 on grant and increment each cycle the grant is held.
REQ-019 In GRANT, the grant SHALL be released at an edge when any holds: done=1, req[gnt_id]=0, or counter == TIMEOUT-1; on release the FSM returns to IDLE and gnt/gnt_id/busy clear at that edge.
REQ-020 An unreleased grant SHALL therefore last at most TIMEOUT cycles.
REQ-021 tmo SHALL pulse high for the one cycle following a release caused solely by timeout (done=0, req[gnt_id]=1); otherwise tmo=0.
REQ-022 On every release, last SHALL be updated to the released gnt_id.
REQ-023 After any release at least one idle cycle (gnt=0) SHALL occur before the next grant (no back-to-back grants).
REQ-024 Requests from non-owners during GRANT SHALL be ignored until the next IDLE arbitration; no preemption.
REQ-025 done asserted in IDLE SHALL be ignored.

Reset
REQ-026 While rst=1 at an edge: state=IDLE, gnt=0, gnt_id=0, busy=0, tmo=0, counter=0, last=3 (so first round-robin search starts at index 0).
REQ-027 rst asserted during GRANT SHALL drop the grant at that edge without updating last beyond its reset value and without a tmo pulse.
REQ-028 rst SHALL take priority over all other inputs at the same edge.

Verification
REQ-029 mode=0, req=4'b0101 held, done=0 -> one cycle after: gnt=4'b0100, gnt_id=2, busy=1; after 8 cycles release, tmo=1 for one cycle, then idle one cycle, then gnt=4'b0100 again.
REQ-030 mode=1 from reset, req=4'b1111, done pulsed 1 cycle after each grant -> gnt_id sequence 0,1,2,3,0, each separated by one idle cycle.
REQ-031 mode=0, req=4'b0010 granted, then req changes to 4'b1010 mid-grant -> gnt stays 4'b0010 until done=1; next grant gnt=4'b1000.
REQ-032 Owner drops req[gnt_id] to 0 with done=0 -> grant released at that edge, tmo=0, busy=0 next cycle.
REQ-033 rst=1 pulsed during GRANT with req=4'b1000 -> gnt=0, busy=0 at that edge; after rst=0, mode=1, req=4'b1001 -> gnt_id=0.
REQ-034 Every cycle: busy=1 implies gnt one-hot and gnt == (1 << gnt_id); busy=0 implies gnt=0, gnt_id=0.
